// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer. Owns the game state and the lives,
// level and score counters, and emits the start/resume/add-life pulses that
// drive the player and enemy blocks.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | counters loaded, waiting for a button press to start
// PLAY     | wave in progress, movement enabled, events evaluated
// RESPAWN  | forced pause after a non-fatal hit, then press to resume
// CLEAR    | wave cleared, timed pause before the next wave starts
// OVER     | game finished, counters frozen, press returns to IDLE
module game_ctrl #(
  parameter int lives_init_p     = 3,
  parameter int max_lives_p      = 7,
  parameter int respawn_frames_p = 60,
  parameter int clear_frames_p   = 120,
  parameter int points_p         = 10
) (
  input  logic        clk_i,
  input  logic        reset_n_async_unsafe_i,
  input  logic        frame_i,
  input  logic        shoot_i,
  input  logic        player_hit_i,
  input  logic        kill_i,
  input  logic        wave_clear_i,
  input  logic        enemy_landed_i,
  output logic [2:0]  state_o,
  output logic        play_o,
  output logic        start_o,
  output logic        resume_o,
  output logic        add_life_o,
  output logic        game_over_o,
  output logic [2:0]  lives_o,
  output logic [3:0]  level_o,
  output logic [15:0] score_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PLAY    = 3'd1,
    ST_RESPAWN = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_OVER    = 3'd4
  } state_t;

  localparam logic [2:0]  LIVES_INIT     = 3'(lives_init_p);
  localparam logic [2:0]  MAX_LIVES      = 3'(max_lives_p);
  localparam logic [7:0]  RESPAWN_FRAMES = 8'(respawn_frames_p);
  localparam logic [7:0]  CLEAR_FRAMES   = 8'(clear_frames_p);
  localparam logic [15:0] POINTS         = 16'(points_p);
  localparam logic [3:0]  LEVEL_MAX      = 4'd15;

  state_t      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [3:0]  level_q, level_d;
  logic [15:0] score_q, score_d;
  logic [16:0] score_sum;
  logic [7:0]  cnt_q, cnt_d;
  logic        shoot_q;
  logic        armed_q;
  logic        shoot_rise;
  logic        start_d, resume_d, add_life_d;
  logic        play_q, over_q;
  logic        start_q, resume_q, add_life_q;

  // The first edge after reset release only captures the button level, so a
  // button held through reset never looks like a fresh press.
  assign shoot_rise = shoot_i & ~shoot_q & armed_q;
  assign score_sum  = {1'b0, score_q} + {1'b0, POINTS};

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, counter updates and pulse requests.
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    level_d    = level_q;
    score_d    = score_q;
    start_d    = 1'b0;
    resume_d   = 1'b0;
    add_life_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lives_d = LIVES_INIT;
        level_d = 4'd1;
        score_d = 16'd0;
        if (shoot_rise) begin
          state_d = ST_PLAY;
          start_d = 1'b1;
        end
      end

      ST_PLAY: begin
        // Kills are scored regardless of which transition wins this cycle.
        if (kill_i) begin
          score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        end
        if (enemy_landed_i) begin
          state_d = ST_OVER;
          lives_d = 3'd0;
        end else if (player_hit_i) begin
          if (lives_q == 3'd1) begin
            state_d = ST_OVER;
            lives_d = 3'd0;
          end else begin
            state_d = ST_RESPAWN;
            lives_d = lives_q - 3'd1;
          end
        end else if (wave_clear_i) begin
          state_d = ST_CLEAR;
          if (level_q != LEVEL_MAX) begin
            level_d = level_q + 4'd1;
          end
          if (lives_q < MAX_LIVES) begin
            lives_d    = lives_q + 3'd1;
            add_life_d = 1'b1;
          end
        end
      end

      ST_RESPAWN: begin
        if ((cnt_q >= RESPAWN_FRAMES) && shoot_rise) begin
          state_d  = ST_PLAY;
          resume_d = 1'b1;
        end
      end

      ST_CLEAR: begin
        if (cnt_q >= CLEAR_FRAMES) begin
          state_d = ST_PLAY;
          start_d = 1'b1;
        end
      end

      ST_OVER: begin
        // Reload on the way out so IDLE shows fresh counters immediately.
        if (shoot_rise) begin
          state_d = ST_IDLE;
          lives_d = LIVES_INIT;
          level_d = 4'd1;
          score_d = 16'd0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Frame counter: restarts on any state change, so a frame strobe on the
  // entry cycle is never counted; saturates rather than wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 8'd0;
    end else if (((state_q == ST_RESPAWN) || (state_q == ST_CLEAR)) && frame_i &&
                 (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counters, button history and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_async_unsafe_i) begin
    if (!reset_n_async_unsafe_i) begin
      lives_q    <= LIVES_INIT;
      level_q    <= 4'd1;
      score_q    <= 16'd0;
      cnt_q      <= 8'd0;
      shoot_q    <= 1'b0;
      armed_q    <= 1'b0;
      play_q     <= 1'b0;
      over_q     <= 1'b0;
      start_q    <= 1'b0;
      resume_q   <= 1'b0;
      add_life_q <= 1'b0;
    end else begin
      lives_q    <= lives_d;
      level_q    <= level_d;
      score_q    <= score_d;
      cnt_q      <= cnt_d;
      shoot_q    <= shoot_i;
      armed_q    <= 1'b1;
      play_q     <= (state_d == ST_PLAY);
      over_q     <= (state_d == ST_OVER);
      start_q    <= start_d;
      resume_q   <= resume_d;
      add_life_q <= add_life_d;
    end
  end

  assign state_o     = state_q;
  assign play_o      = play_q;
  assign game_over_o = over_q;
  assign start_o     = start_q;
  assign resume_o    = resume_q;
  assign add_life_o  = add_life_q;
  assign lives_o     = lives_q;
  assign level_o     = level_q;
  assign score_o     = score_q;

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the Space Invaders design on the 25 MHz pixel clock. It owns game state (idle, playing, respawn, level clear, game over) and the lives, level and score counters. It emits the start, resume and add-life pulses that drive `player` and `enemy`, and the `play_o` enable that gates movement. It consumes the synchronized centre button, the per-frame strobe, and hit/kill/landed events from the datapath.

## Interface
- `lives_init_p`, 3: lives loaded in IDLE; must be 1..`max_lives_p`.
- `max_lives_p`, 7: add-life ceiling; must be ≤ 7 (3-bit counter).
- `respawn_frames_p`, 60: frames of forced pause after a non-fatal hit.
- `clear_frames_p`, 120: frames shown between waves.
- `points_p`, 10: score added per kill.

Ports:
- `clk_i` in 1: pixel clock (25 MHz).
- `reset_n_async_unsafe_i` in 1: reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `frame_i` in 1: one-cycle strobe, once per frame.
- `shoot_i` in 1: synchronized centre button, level.
- `player_hit_i` in 1: one-cycle pulse, player struck.
- `kill_i` in 1: one-cycle pulse, one enemy destroyed.
- `wave_clear_i` in 1: level, all enemies of the wave dead.
- `enemy_landed_i` in 1: level, an enemy reached the player row.
- `state_o` out 3: IDLE=0, PLAY=1, RESPAWN=2, CLEAR=3, OVER=4.
- `play_o` out 1: high only in PLAY.
- `start_o` out 1: one-cycle pulse, new wave begins.
- `resume_o` out 1: one-cycle pulse, play resumes after respawn.
- `add_life_o` out 1: one-cycle pulse, bonus life granted.
- `game_over_o` out 1: high only in OVER.
- `lives_o` out 3: remaining lives.
- `level_o` out 4: current level, 1..15.
- `score_o` out 16: score, saturating.

## Operation
- **Shoot edge:** `shoot_i` is registered once; `shoot_rise` = `shoot_i & ~shoot_q`. All button actions use `shoot_rise` only.
- **Frame counter:** 8-bit, cleared on every state entry, incremented on `frame_i` in RESPAWN and CLEAR.
- **IDLE:**
  - Load `lives_o`=`lives_init_p`, `level_o`=1, `score_o`=0.
  - `shoot_rise` → PLAY; pulse `start_o`.
- **PLAY** (priority, highest first, evaluated each cycle):
  - `enemy_landed_i` → OVER; `lives_o`←0.
  - `player_hit_i`: if `lives_o`==1 → OVER with `lives_o`←0; else `lives_o`−1 → RESPAWN.
  - `wave_clear_i` → CLEAR.
  - Otherwise stay.
- **Scoring:** a `kill_i` in PLAY adds `points_p`, saturating at 16'hFFFF. This holds even in the cycle a transition is taken. `kill_i` outside PLAY is ignored.
- **RESPAWN:**
  - Wait until the frame counter reaches `respawn_frames_p`.
  - Then `shoot_rise` → PLAY; pulse `resume_o`.
  - `shoot_rise` before expiry is ignored; it is not latched.
- **CLEAR entry** (on the cycle PLAY→CLEAR is taken):
  - `level_o`+1, saturating at 15.
  - If `lives_o` < `max_lives_p`: `lives_o`+1 and pulse `add_life_o`.
  - After `clear_frames_p` frames → PLAY; pulse `start_o`. No button is needed.
- **OVER:**
  - `game_over_o`=1; counters hold.
  - `shoot_rise` → IDLE; counters reload there. A second press is required to start.
- **Event handling:** hit/landed/wave events outside PLAY are ignored.

## Timing
- **Registration:** all outputs are registered; pulses are exactly one cycle wide.
- **Latency:** an input sampled at edge N produces the state change, counter update and pulse visible after edge N, i.e. 1-cycle latency.
- **Simultaneous events:** resolved by the PLAY priority list; a kill is still scored alongside any of them.
- **Reset** (asynchronous assert; takes effect at any point, including mid-wave or mid-count):
  - State=IDLE, `play_o`=0, all pulses 0, `game_over_o`=0.
  - `lives_o`=`lives_init_p`, `level_o`=1, `score_o`=0, frame counter=0, `shoot_q`=0.
- **Button held through reset:** if `shoot_i` is high at reset release, `shoot_q` captures it without a rise. The game does not start until release and re-press.
- **Frame timing:** `frame_i` arriving on the same cycle as a state entry is not counted. Expiry compares count ≥ parameter, so a parameter of 0 means immediate.

## Test plan
- **Start:** reset, hold `shoot_i`=1 across release → stays IDLE. Release, press → `start_o` pulse, `state_o`=1, `play_o`=1, `lives_o`=3, `level_o`=1.
- **Hit and respawn:** in PLAY, pulse `player_hit_i` → `lives_o`=2, `state_o`=2. Press at frame 30 → ignored. After 60 `frame_i` strobes, press → `resume_o` pulse, `state_o`=1.
- **Wave clear:** in PLAY with `lives_o`=3, raise `wave_clear_i` → `state_o`=3, `level_o`=2, `lives_o`=4, `add_life_o` pulse. After 120 frames → `start_o` pulse, PLAY. Repeat at `lives_o`=7 → no `add_life_o`, lives stay 7.
- **Simultaneous events:** assert `player_hit_i`, `wave_clear_i` and `kill_i` in one cycle with `lives_o`=2 → RESPAWN, `lives_o`=1, `score_o`+10, `level_o` unchanged.
- **Game over:** `enemy_landed_i` with `lives_o`=3 → OVER, `lives_o`=0, `game_over_o`=1. Press → IDLE with lives 3, level 1, score 0. Press → PLAY.
- **Saturation and reset:** preload score to 65530, one kill → 65535; another kill → 65535. Assert reset mid-CLEAR → all outputs return to reset values immediately, without waiting for a clock edge.
